fetch_unit: RTL

Instruction-fetch stage of the 5-stage RISC-V core. It owns the PC register, issues addresses to the synchronous instruction memory, and feeds the IF/ID pipeline register. It consumes the redirect (PcSel/BrPC) produced by the branch unit in EX. It handles hazard-unit stalls without losing the in-flight instruction, and squashes wrong-path fetches on a taken branch or jump.

---
 rtl/core_pkg.sv | 25 ++
 rtl/fetch_skid.sv | 61 ++++++
 rtl/fetch_unit.sv | 73 +++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: fetch widths, the canonical NOP, the fetch
// stall-FSM states and the IF/ID pipeline-register layout used by decode.
package core_pkg;

  localparam int PC_W   = 9;
  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] instr;
    logic              valid;
  } if_id_t;

  // Sequential PC, wrapping modulo 2^PC_W.
  function automatic logic [PC_W-1:0] pc_plus4(input logic [PC_W-1:0] pc);
    return pc + PC_W'(4);
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// RUN/HOLD stall FSM with the hold register that keeps the F2 instruction
// alive while the memory keeps re-reading the frozen PC.
module fetch_skid
  import core_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect,
  input  logic              req_valid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              advance,
  output logic [INST_W-1:0] fwd_instr
);

  fetch_state_e      state_q;
  fetch_state_e      state_d;
  logic [INST_W-1:0] hold_instr;
  logic              capture;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      hold_instr <= '0;
    end else begin
      state_q <= state_d;
      if (capture) hold_instr <= imem_rdata;
    end
  end

  // Memory data is only trustworthy for ReqPC on the first stalled cycle,
  // so capture happens on RUN->HOLD and never again until release.
  always_comb begin
    state_d   = state_q;
    advance   = 1'b0;
    capture   = 1'b0;
    fwd_instr = (state_q == HOLD) ? hold_instr : imem_rdata;
    if (redirect) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (stall) begin
            state_d = HOLD;
            capture = req_valid;
          end else begin
            advance = 1'b1;
          end
        end
        HOLD: begin
          if (!stall) begin
            state_d = RUN;
            advance = 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, redirect/squash handling and the
// IF/ID register, with stall handling delegated to fetch_skid.
module fetch_unit
  import core_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              PcSel,
  input  logic [31:0]       BrPC,
  input  logic              Stall,
  output logic [PC_W-1:0]   ImemAddr,
  input  logic [INST_W-1:0] ImemRdata,
  output logic [PC_W-1:0]   IfPC,
  output logic [INST_W-1:0] IfInstr,
  output logic              IfValid,
  output logic              MisalignErr
);

  logic [PC_W-1:0]   pc_q;
  logic [PC_W-1:0]   req_pc;
  logic              req_valid;
  if_id_t            if_id;
  logic              misalign_q;
  logic              advance;
  logic [INST_W-1:0] fwd_instr;
  logic              unused_br_hi;

  assign unused_br_hi = ^BrPC[31:PC_W];

  fetch_skid u_skid (
    .clk        (clk),
    .reset      (reset),
    .stall      (Stall),
    .redirect   (PcSel),
    .req_valid  (req_valid),
    .imem_rdata (ImemRdata),
    .advance    (advance),
    .fwd_instr  (fwd_instr)
  );

  // A redirect squashes both F2 and IF/ID; the correct path refills in 2 cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= '0;
      req_pc     <= '0;
      req_valid  <= 1'b0;
      if_id      <= '{pc: '0, instr: NOP_INSTR, valid: 1'b0};
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= PcSel && (BrPC[1:0] != 2'b00);
      if (PcSel) begin
        pc_q        <= {BrPC[PC_W-1:2], 2'b00};
        req_valid   <= 1'b0;
        if_id.instr <= NOP_INSTR;
        if_id.valid <= 1'b0;
      end else if (advance) begin
        pc_q      <= pc_plus4(pc_q);
        req_pc    <= pc_q;
        req_valid <= 1'b1;
        if_id     <= '{pc: req_pc,
                       instr: (req_valid ? fwd_instr : NOP_INSTR),
                       valid: req_valid};
      end
    end
  end

  assign ImemAddr    = pc_q;
  assign IfPC        = if_id.pc;
  assign IfInstr     = if_id.valid ? if_id.instr : NOP_INSTR;
  assign IfValid     = if_id.valid;
  assign MisalignErr = misalign_q;

endmodule
